id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_W, default 176, width of the datapath payload: PC+4, two read operands, sign-extended immediate, two register indices.
REQ-002 Parameter CTRL_W, default 16, width of the control payload: the decoder control bits plus alu_op.
REQ-003 Parameter HALT_BIT, default 9, index within in_ctrl that marks a halt instruction.
REQ-004 Parameter SKID, default 1; 1 = two-entry skid stage with registered in_ready, 0 = single register with combinational in_ready.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 in_valid  input  1  ID stage presents a beat.
REQ-008 in_ready  output  1  stage accepts the beat this cycle.
REQ-009 in_ctrl  input  CTRL_W  control payload.
REQ-010 in_data  input  DATA_W  datapath payload.
REQ-011 flush  input  1  squash all held beats (branch taken or exception).
REQ-012 out_valid  output  1  EX-side beat present.
REQ-013 out_ready  input  1  EX stage consumes the beat.
REQ-014 out_ctrl  output  CTRL_W  registered control payload; all zero whenever out_valid=0.
REQ-015 out_data  output  DATA_W  registered datapath payload.
REQ-016 halted  output  1  sticky; the halt beat has left the stage.
REQ-017 beat_count  output  32  number of beats transferred at the output, wraps modulo 2^32.

Function
REQ-018 An input beat transfers when in_valid and in_ready are both 1; an output beat transfers when out_valid and out_ready are both 1.
REQ-019 Beats leave in acceptance order; no beat is dropped or duplicated except by flush.
REQ-020 SKID=1: main register drives the outputs; the skid register captures an accepted beat while main is full and not draining.
REQ-021 SKID=1: in_ready = ~skid_valid & ~halt_seen & ~rst; depends on registered state only.
REQ-022 SKID=1 on output transfer: main loads skid if skid_valid, else loads the input beat if accepted, else goes empty.
REQ-023 SKID=0: in_ready = (~out_valid | out_ready) & ~halt_seen & ~rst; main loads the input beat on each accept.
REQ-024 Latency: an accepted beat appears on out_* in the next cycle when the stage is empty.
REQ-025 Peak throughput is one beat per cycle under continuous in_valid and out_ready, for both SKID values.
REQ-026 halt_seen is set in the cycle after a beat is accepted with in_ctrl[HALT_BIT]=1; no further beats are then accepted.
REQ-027 halted is set in the cycle after the halt beat's output transfer and holds until reset.
REQ-028 flush=1 clears main and skid valid, zeroes out_ctrl, and drops any same-cycle input beat.
REQ-029 flush has priority over the handshakes and does not count a same-cycle output transfer.
REQ-030 flush clears halt_seen only if the halt beat has not yet transferred out; flush never clears halted.
REQ-031 beat_count increments by 1 per output transfer, with 32-bit wrap from 0xFFFFFFFF to 0.
REQ-032 Stall (out_ready=0) holds out_ctrl and out_data stable while out_valid=1.

Reset
REQ-033 rst=1 at a posedge clears out_valid, skid_valid, halt_seen, halted, beat_count, out_ctrl and out_data to 0.
REQ-034 rst overrides flush and both handshakes; in_ready=0 while rst=1.
REQ-035 rst asserted mid-stream discards all held beats; the first beat after reset is accepted in the first cycle with rst=0.

Verification
REQ-036 SKID=1, out_ready=1, ten back-to-back beats with in_data=1..10 -> out_data=1..10 on consecutive cycles starting one cycle after the first accept; beat_count=10.
REQ-037 SKID=1, out_ready=0 with beats A,B offered -> A held on out, B in skid, in_ready=0; then out_ready=1 -> A, then B, with no gap.
REQ-038 Beat with in_ctrl[9]=1 followed by in_valid held high -> in_ready=0 from the next cycle; halted=1 the cycle after the halt beat's output transfer.
REQ-039 Two beats held (main and skid), flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, beat_count unchanged.
REQ-040 beat_count preloaded to 0xFFFFFFFF by forcing, one output transfer -> beat_count=0.
REQ-041 SKID=0 with out_ready toggling 1,0,1 -> in_ready follows out_ready combinationally while full; ordering preserved; rst mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshakes on both sides.
// SKID=1 adds a second holding register so in_ready depends on registered
// state only; SKID=0 is a single register whose in_ready looks through to
// out_ready. A halt beat closes the input side and raises a sticky halted
// flag once it has left the stage.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W   = 176,
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned HALT_BIT = 9,
  parameter int unsigned SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [31:0]       beat_count
);

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              halt_seen_q,  halt_seen_d;
  logic              halted_q,     halted_d;
  logic [31:0]       beat_count_q, beat_count_d;

  logic in_fire;
  logic out_fire;

  // Input acceptance: skid variant uses registered state only.
  always_comb begin
    if (SKID != 0) begin
      in_ready = ~skid_valid_q & ~halt_seen_q & ~rst;
    end else begin
      in_ready = (~main_valid_q | out_ready) & ~halt_seen_q & ~rst;
    end
  end

  // Flush squashes both sides of the handshake for this cycle.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = main_valid_q & out_ready & ~flush;

  // Payload steering between input, skid and main registers.
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Data is left as-is; only valid and the visible control are cleared.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (!main_valid_q) begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end
    end else if (in_fire && (SKID != 0)) begin
      // Main is full and stalled: park the beat in the skid register.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  // Halt tracking and output beat counter.
  always_comb begin
    halt_seen_d  = halt_seen_q;
    halted_d     = halted_q;
    beat_count_d = beat_count_q;

    // Once the halt beat is gone a flush cannot reopen the input side.
    if (flush && !halted_q) begin
      halt_seen_d = 1'b0;
    end else if (in_fire && in_ctrl[HALT_BIT]) begin
      halt_seen_d = 1'b1;
    end

    if (out_fire && main_ctrl_q[HALT_BIT]) begin
      halted_d = 1'b1;
    end

    if (out_fire) begin
      beat_count_d = beat_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      halt_seen_q  <= 1'b0;
      halted_q     <= 1'b0;
      beat_count_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      halt_seen_q  <= halt_seen_d;
      halted_q     <= halted_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign halted     = halted_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a per-cycle vector table drives the SKID=1
// instance while a scoreboard tracks accepted beats in order; hand-written
// sequences cover counter wrap and the SKID=0 instance.
module tb_id_ex_pipe_reg;
  localparam int DW = 176;
  localparam int CW = 16;

  logic clk;
  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  // SKID=1 instance signals
  logic          rst1, iv1, ir1, fl1, ov1, or1, hl1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [31:0]   bc1;

  // SKID=0 instance signals
  logic          rst0, iv0, ir0, fl0, ov0, or0, hl0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [31:0]   bc0;

  id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(9), .SKID(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1),
    .in_data(id1), .flush(fl1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .halted(hl1), .beat_count(bc1)
  );

  id_ex_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .HALT_BIT(9), .SKID(0)) dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0),
    .in_data(id0), .flush(fl0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .halted(hl0), .beat_count(bc0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          rst;
    logic          iv;
    logic [7:0]    data;
    logic          hlt;
    logic          ordy;
    logic          fl;
    logic          eir;
    logic          eov;
    logic [31:0]   ecnt;
    logic          ehalt;
  } vec_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  vec_t  tbl[$];
  beat_t exp_q[$];

  function automatic logic [CW-1:0] mk_ctrl(input logic [7:0] d, input logic h);
    return {6'd0, h, 1'b0, d};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [7:0] d);
    return {{(DW-8){1'b0}}, d};
  endfunction

  task automatic add(input logic r, input logic iv, input int d, input logic h,
                     input logic ordy, input logic fl, input logic eir,
                     input logic eov, input int ec, input logic eh);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d[7:0]; v.hlt = h; v.ordy = ordy; v.fl = fl;
    v.eir = eir; v.eov = eov; v.ecnt = ec; v.ehalt = eh;
    tbl.push_back(v);
  endtask

  // Scoreboard for dut1: pop on output transfer, push on input accept.
  task automatic sb1();
    beat_t b;
    if (rst1 || fl1) begin
      exp_q.delete();
    end else begin
      if (ov1 && or1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow: got beat %0h expected none", od1);
        end else begin
          b = exp_q.pop_front();
          chk("sb_ctrl", 192'(oc1), 192'(b.c));
          chk("sb_data", 192'(od1), 192'(b.d));
        end
      end
      if (iv1 && ir1) begin
        b.c = ic1;
        b.d = id1;
        exp_q.push_back(b);
      end
    end
  endtask

  initial begin
    rst1 = 1'b1; iv1 = 1'b0; ic1 = '0; id1 = '0; fl1 = 1'b0; or1 = 1'b0;
    rst0 = 1'b1; iv0 = 1'b0; ic0 = '0; id0 = '0; fl0 = 1'b0; or0 = 1'b0;

    // Vector table: r, iv, data, hlt, ordy, fl | in_ready, out_valid, count, halted
    // ten back-to-back beats
    for (int k = 1; k <= 10; k++)
      add(0, 1, k, 0, 1, 0, 1, (k >= 2), (k >= 2) ? k - 2 : 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 9, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 10, 0);
    // stall fills main and skid, then drains without a gap
    add(0, 1, 11, 0, 0, 0, 1, 0, 10, 0);
    add(0, 1, 12, 0, 0, 0, 1, 1, 10, 0);
    add(0, 1, 13, 0, 0, 0, 0, 1, 10, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 10, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 11, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 12, 0);
    // flush with two beats held and a same-cycle input and output offer
    add(0, 1, 21, 0, 0, 0, 1, 0, 12, 0);
    add(0, 1, 22, 0, 0, 0, 1, 1, 12, 0);
    add(0, 1, 23, 0, 1, 1, 0, 1, 12, 0);
    add(0, 1, 24, 0, 0, 0, 1, 0, 12, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 12, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 13, 0);
    // halt beat; flush after it left must not reopen the input
    add(0, 1, 31, 1, 0, 0, 1, 0, 13, 0);
    add(0, 1, 32, 0, 0, 0, 0, 1, 13, 0);
    add(0, 1, 33, 0, 1, 0, 0, 1, 13, 0);
    add(0, 1, 34, 0, 1, 0, 0, 0, 14, 1);
    add(0, 1, 35, 0, 1, 1, 0, 0, 14, 1);
    add(0, 1, 36, 0, 1, 0, 0, 0, 14, 1);
    // reset, then a halt beat flushed before it leaves
    add(1, 1, 40, 0, 1, 0, 0, 0, 14, 1);
    add(0, 1, 41, 1, 0, 0, 1, 0, 0, 0);
    add(0, 1, 42, 0, 0, 1, 0, 1, 0, 0);
    add(0, 1, 43, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    // reset mid-stream with main and skid full
    add(0, 1, 51, 0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 52, 0, 0, 0, 1, 1, 1, 0);
    add(1, 1, 53, 0, 0, 0, 0, 1, 1, 0);
    add(0, 1, 54, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 1, 0);

    // Reset state of both instances
    @(negedge clk);
    #1;
    chk("rst_in_ready", 192'(ir1), 192'(0));
    chk("rst_out_valid", 192'(ov1), 192'(0));
    chk("rst_out_ctrl", 192'(oc1), 192'(0));
    chk("rst_out_data", 192'(od1), 192'(0));
    chk("rst_halted", 192'(hl1), 192'(0));
    chk("rst_count", 192'(bc1), 192'(0));
    chk("rst0_in_ready", 192'(ir0), 192'(0));
    chk("rst0_out_valid", 192'(ov0), 192'(0));
    @(negedge clk);

    foreach (tbl[i]) begin
      rst1 = tbl[i].rst;
      iv1  = tbl[i].iv;
      ic1  = mk_ctrl(tbl[i].data, tbl[i].hlt);
      id1  = mk_data(tbl[i].data);
      or1  = tbl[i].ordy;
      fl1  = tbl[i].fl;
      #1;
      chk($sformatf("row%0d_in_ready", i), 192'(ir1), 192'(tbl[i].eir));
      chk($sformatf("row%0d_out_valid", i), 192'(ov1), 192'(tbl[i].eov));
      chk($sformatf("row%0d_count", i), 192'(bc1), 192'(tbl[i].ecnt));
      chk($sformatf("row%0d_halted", i), 192'(hl1), 192'(tbl[i].ehalt));
      if (!ov1) chk($sformatf("row%0d_ctrl_zero", i), 192'(oc1), 192'(0));
      if (i > 0 && tbl[i-1].rst) chk($sformatf("row%0d_rst_data", i), 192'(od1), 192'(0));
      sb1();
      @(negedge clk);
    end

    // Counter wrap from a preloaded all-ones value
    rst1 = 1'b0; fl1 = 1'b0; iv1 = 1'b1; or1 = 1'b0;
    ic1 = mk_ctrl(8'd71, 1'b0);
    id1 = mk_data(8'd71);
    #1;
    sb1();
    @(negedge clk);
    iv1 = 1'b0;
    force dut1.beat_count_q = 32'hFFFF_FFFF;
    #1;
    release dut1.beat_count_q;
    #1;
    chk("wrap_preload", 192'(bc1), 192'(32'hFFFF_FFFF));
    or1 = 1'b1;
    #1;
    chk("wrap_out_valid", 192'(ov1), 192'(1));
    sb1();
    @(negedge clk);
    #1;
    chk("wrap_count", 192'(bc1), 192'(0));
    chk("wrap_empty", 192'(ov1), 192'(0));
    chk("sb_drained", 192'(exp_q.size()), 192'(0));

    // SKID=0: combinational in_ready, ordering, reset mid-stream
    @(negedge clk);
    rst0 = 1'b0; iv0 = 1'b1; or0 = 1'b1;
    ic0 = mk_ctrl(8'd61, 1'b0); id0 = mk_data(8'd61);
    #1;
    chk("s0_ir_empty", 192'(ir0), 192'(1));
    chk("s0_ov_empty", 192'(ov0), 192'(0));
    @(negedge clk);
    ic0 = mk_ctrl(8'd62, 1'b0); id0 = mk_data(8'd62);
    #1;
    chk("s0_first_valid", 192'(ov0), 192'(1));
    chk("s0_first_data", 192'(od0), 192'(mk_data(8'd61)));
    chk("s0_first_ctrl", 192'(oc0), 192'(mk_ctrl(8'd61, 1'b0)));
    chk("s0_ir_drain", 192'(ir0), 192'(1));
    @(negedge clk);
    ic0 = mk_ctrl(8'd63, 1'b0); id0 = mk_data(8'd63); or0 = 1'b0;
    #1;
    chk("s0_ir_follow_lo", 192'(ir0), 192'(0));
    or0 = 1'b1;
    #1;
    chk("s0_ir_follow_hi", 192'(ir0), 192'(1));
    or0 = 1'b0;
    #1;
    chk("s0_ir_follow_lo2", 192'(ir0), 192'(0));
    chk("s0_second_data", 192'(od0), 192'(mk_data(8'd62)));
    @(negedge clk);
    or0 = 1'b1;
    #1;
    chk("s0_stall_hold", 192'(od0), 192'(mk_data(8'd62)));
    chk("s0_stall_valid", 192'(ov0), 192'(1));
    @(negedge clk);
    ic0 = mk_ctrl(8'd64, 1'b0); id0 = mk_data(8'd64);
    #1;
    chk("s0_third_data", 192'(od0), 192'(mk_data(8'd63)));
    @(negedge clk);
    rst0 = 1'b1; ic0 = mk_ctrl(8'd65, 1'b0); id0 = mk_data(8'd65);
    #1;
    chk("s0_fourth_data", 192'(od0), 192'(mk_data(8'd64)));
    chk("s0_count", 192'(bc0), 192'(3));
    chk("s0_ir_rst", 192'(ir0), 192'(0));
    @(negedge clk);
    rst0 = 1'b0; iv0 = 1'b0;
    #1;
    chk("s0_post_rst_valid", 192'(ov0), 192'(0));
    chk("s0_post_rst_ctrl", 192'(oc0), 192'(0));
    chk("s0_post_rst_data", 192'(od0), 192'(0));
    chk("s0_post_rst_count", 192'(bc0), 192'(0));
    chk("s0_post_rst_halted", 192'(hl0), 192'(0));
    chk("s0_post_rst_ir", 192'(ir0), 192'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
